dbus_gather: RTL and testbench

Read-side companion to the Tom data-bus upward replicator. It assembles a full 64-bit phrase from successive narrow read beats returned by 8-, 16- or 32-bit memories on the low lanes of the data bus. It also passes 64-bit reads straight through, and presents the result to the internal bus with a one-cycle valid pulse. It sits between the memory-controller read data path and the internal 64-bit data bus consumers (object processor, blitter, GPU).

---
 rtl/dbus_gather_if.sv | 23 ++
 rtl/dbus_gather.sv | 134 +++++++++++++
 tb/tb_dbus_gather.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dbus_gather_if.sv
// Read-gather bus bundle: request/beat inputs from the memory side and the
// assembled-phrase outputs toward the internal 64-bit bus consumers.
interface dbus_gather_if;
  logic        start;
  logic [1:0]  width;
  logic        rdstrb;
  logic [63:0] din;
  logic        abort;
  logic [63:0] dout;
  logic        dvalid;
  logic        busy;
  logic [7:0]  bmask;

  modport master (
    output start, width, rdstrb, din, abort,
    input  dout, dvalid, busy, bmask
  );

  modport slave (
    input  start, width, rdstrb, din, abort,
    output dout, dvalid, busy, bmask
  );
endinterface

// File: rtl/dbus_gather.sv
// Assembles a 64-bit phrase from 8/16/32-bit read beats (or passes a 64-bit
// beat through) and flags completion with a one-cycle dvalid pulse.
module dbus_gather (
  input  logic           sys_clk,
  input  logic           resetl,
  dbus_gather_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GATHER = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Byte lanes covered by one beat, before shifting to its lane offset.
  function automatic logic [7:0] beat_lanes(input logic [1:0] w);
    logic [7:0] m;
    case (w)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] w);
    logic [2:0] l;
    case (w)
      2'b00:   l = 3'd7;
      2'b01:   l = 3'd3;
      2'b10:   l = 3'd1;
      2'b11:   l = 3'd0;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  function automatic logic [63:0] expand_bytes(input logic [7:0] m);
    logic [63:0] e;
    for (int n = 0; n < 8; n++) begin
      e[8*n +: 8] = {8{m[n]}};
    end
    return e;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [1:0]  wreg_q, wreg_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] dout_q, dout_d;
  logic [7:0]  bmask_q, bmask_d;
  logic        dvalid_q;
  logic        busy_q;

  logic [2:0]  off_s;
  logic [7:0]  beat_mask_s;
  logic [63:0] beat_bits_s;
  logic [63:0] din_sh_s;
  logic        last_s;

  // Lane offset in bytes is idx * Wbytes, i.e. idx shifted by log2(Wbytes).
  assign off_s       = idx_q << wreg_q;
  assign beat_mask_s = beat_lanes(wreg_q) << off_s;
  assign beat_bits_s = expand_bytes(beat_mask_s);
  assign din_sh_s    = bus.din << {off_s, 3'b000};
  assign last_s      = (idx_q == last_idx(wreg_q));

  // Next-state and datapath update for the gather FSM.
  always_comb begin
    state_d = state_q;
    wreg_d  = wreg_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    bmask_d = bmask_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_GATHER;
          wreg_d  = bus.width;
          idx_d   = 3'd0;
          bmask_d = 8'h00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GATHER: begin
        // abort beats a coincident rdstrb; the beat is dropped.
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.rdstrb) begin
          dout_d  = (dout_q & ~beat_bits_s) | (din_sh_s & beat_bits_s);
          bmask_d = bmask_q | beat_mask_s;
          idx_d   = idx_q + 3'd1;
          if (last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GATHER;
          end
        end else begin
          state_d = ST_GATHER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q  <= ST_IDLE;
      wreg_q   <= 2'b00;
      idx_q    <= 3'd0;
      dout_q   <= 64'd0;
      bmask_q  <= 8'h00;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wreg_q   <= wreg_d;
      idx_q    <= idx_d;
      dout_q   <= dout_d;
      bmask_q  <= bmask_d;
      dvalid_q <= (state_d == ST_DONE);
      busy_q   <= (state_d == ST_GATHER);
    end
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.busy   = busy_q;
  assign bus.bmask  = bmask_q;

endmodule

// File: tb/tb_dbus_gather.sv
// Directed bench for dbus_gather: hand-computed phrases, masks and pulse timing.
module tb_dbus_gather;

  logic sys_clk;
  logic resetl;
  int   errors;
  int   checks;
  int   pulses;
  int   p0;

  dbus_gather_if bus ();

  dbus_gather dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Count dvalid pulses on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    if (bus.dvalid) pulses++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One active edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.rdstrb = 1'b0;
    bus.abort  = 1'b0;
    bus.din    = 64'd0;
  endtask

  task automatic beat(input logic [63:0] d);
    bus.rdstrb = 1'b1;
    bus.din    = d;
    step();
    bus.rdstrb = 1'b0;
  endtask

  task automatic begin_gather(input logic [1:0] w);
    bus.start = 1'b1;
    bus.width = w;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pulses = 0;
    resetl = 1'b0;
    bus.width = 2'b00;
    idle_inputs();
    step();
    step();
    check("rst_dout", bus.dout, 64'd0);
    check("rst_dvalid", {63'd0, bus.dvalid}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_bmask", {56'd0, bus.bmask}, 64'd0);
    resetl = 1'b1;
    step();

    // 16-bit gather, consecutive beats
    begin_gather(2'b01);
    check("w16_busy", {63'd0, bus.busy}, 64'd1);
    p0 = pulses;
    beat(64'h0000_0000_0000_1111);
    beat(64'h0000_0000_0000_2222);
    beat(64'h0000_0000_0000_3333);
    check("w16_nodv3", {63'd0, bus.dvalid}, 64'd0);
    beat(64'h0000_0000_0000_4444);
    check("w16_dvalid", {63'd0, bus.dvalid}, 64'd1);
    check("w16_busy_done", {63'd0, bus.busy}, 64'd0);
    check("w16_dout", bus.dout, 64'h4444_3333_2222_1111);
    check("w16_bmask", {56'd0, bus.bmask}, 64'hFF);
    step();
    check("w16_dv_off", {63'd0, bus.dvalid}, 64'd0);
    check("w16_pulses", 64'(pulses - p0), 64'd1);

    // 8-bit gather with two idle cycles between beats; upper din bits are junk
    p0 = pulses;
    begin_gather(2'b00);
    for (int i = 1; i <= 8; i++) begin
      beat({56'hA5A5_A5A5_A5A5_A5, 8'(i)});
      if (i == 8) begin
        check("w8_dvalid", {63'd0, bus.dvalid}, 64'd1);
        check("w8_dout", bus.dout, 64'h0807_0605_0403_0201);
      end else if (i == 4) begin
        check("w8_bmask4", {56'd0, bus.bmask}, 64'h0F);
      end else begin
        check("w8_busy", {63'd0, bus.busy}, 64'd1);
      end
      step();
      step();
    end
    check("w8_pulses", 64'(pulses - p0), 64'd1);

    // 64-bit back-to-back with start in the DONE cycle
    begin_gather(2'b11);
    beat(64'hDEAD_BEEF_CAFE_F00D);
    check("b2b_dv1", {63'd0, bus.dvalid}, 64'd1);
    check("b2b_dout1", bus.dout, 64'hDEAD_BEEF_CAFE_F00D);
    bus.start = 1'b1;
    bus.width = 2'b11;
    step();
    bus.start = 1'b0;
    check("b2b_gap", {63'd0, bus.dvalid}, 64'd0);
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    beat(64'h0123_4567_89AB_CDEF);
    check("b2b_dv2", {63'd0, bus.dvalid}, 64'd1);
    check("b2b_dout2", bus.dout, 64'h0123_4567_89AB_CDEF);
    step();

    // Abort mid 32-bit gather over a prior all-ones phrase
    begin_gather(2'b11);
    beat(64'hFFFF_FFFF_FFFF_FFFF);
    step();
    p0 = pulses;
    begin_gather(2'b10);
    beat(64'h1234_5678_AABB_CCDD);
    check("abt_bmask1", {56'd0, bus.bmask}, 64'h0F);
    bus.abort = 1'b1;
    beat(64'h9988_7766_5544_3322);
    bus.abort = 1'b0;
    check("abt_busy", {63'd0, bus.busy}, 64'd0);
    check("abt_dout", bus.dout, 64'hFFFF_FFFF_AABB_CCDD);
    check("abt_bmask", {56'd0, bus.bmask}, 64'h0F);
    step();
    step();
    check("abt_pulses", 64'(pulses - p0), 64'd0);

    // rdstrb while idle must not touch dout
    beat(64'h0000_0000_0000_0000);
    check("idle_rd_dout", bus.dout, 64'hFFFF_FFFF_AABB_CCDD);
    check("idle_rd_busy", {63'd0, bus.busy}, 64'd0);

    // start during GATHER is ignored; width stays 16-bit
    begin_gather(2'b01);
    beat(64'h0000_0000_0000_5555);
    bus.start = 1'b1;
    bus.width = 2'b00;
    beat(64'h0000_0000_0000_6666);
    bus.start = 1'b0;
    beat(64'h0000_0000_0000_7777);
    beat(64'h0000_0000_0000_8888);
    check("ign_dvalid", {63'd0, bus.dvalid}, 64'd1);
    check("ign_dout", bus.dout, 64'h8888_7777_6666_5555);
    step();

    // Asynchronous reset mid-gather, then a clean 32-bit gather
    begin_gather(2'b10);
    beat(64'h0000_0000_1122_3344);
    resetl = 1'b0;
    #1;
    check("arst_dout", bus.dout, 64'd0);
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_bmask", {56'd0, bus.bmask}, 64'd0);
    step();
    resetl = 1'b1;
    step();
    begin_gather(2'b10);
    beat(64'h0000_0000_CAFE_BABE);
    check("post_nodv", {63'd0, bus.dvalid}, 64'd0);
    beat(64'h0000_0000_0BAD_F00D);
    check("post_dvalid", {63'd0, bus.dvalid}, 64'd1);
    check("post_dout", bus.dout, 64'h0BAD_F00D_CAFE_BABE);
    check("post_bmask", {56'd0, bus.bmask}, 64'hFF);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
